// File: rtl/vecdeser.sv
// vecdeser: streaming scalar-to-vector deserializer.
// Packs COLS signed WIDTH-bit elements, accepted one per in handshake, into a
// registered vector. The vector is presented with its own valid/ready handshake.
// The first element accepted lands in o_f[1].
// Optional feature macro: VECDESER_MIN_EN adds o_fmin, the running signed
// minimum of the vector, which is valid whenever o_f_valid is 1.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | collecting elements into o_f[cnt+1], cnt = 0..COLS-1
// FULL  | vector complete, o_f_valid = 1, waiting for the consumer
module vecdeser #(
    parameter int COLS  = 4,
    parameter int WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic signed [WIDTH-1:0]       i_in_data,
    output logic [COLS:1][WIDTH-1:0]      o_f,
`ifdef VECDESER_MIN_EN
    output logic signed [WIDTH-1:0]       o_fmin,
`endif
    output logic                          o_f_valid,
    input  logic                          i_f_ready
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_cnt;
    logic [COLS:1][WIDTH-1:0] r_f;
    logic                     w_accept;
    logic                     w_out;
    logic                     w_last;
    logic [COLS:1]            w_wr_sel;

    assign w_last   = (r_cnt == CW'(COLS - 1));
    assign w_accept = i_in_valid && o_in_ready;
    assign w_out    = o_f_valid && i_f_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; with COLS == 1 a simultaneous drain and refill keeps FULL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && w_last) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_out) begin
                    w_state_nxt = (w_accept && (COLS == 1)) ? FULL : FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Output logic: handshake flags and one-hot element write select
    always_comb begin
        o_in_ready = !i_reset && ((r_state == FILL) || i_f_ready);
        o_f_valid  = (r_state == FULL);
        w_wr_sel   = '0;
        if (w_accept) begin
            if (r_state == FULL) begin
                w_wr_sel[1] = 1'b1;
            end else begin
                for (int i = 1; i <= COLS; i++) begin
                    if (r_cnt == CW'(i - 1)) begin
                        w_wr_sel[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Datapath: element counter and vector storage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_f   <= '0;
        end else begin
            if (w_accept) begin
                if (r_state == FULL) begin
                    r_cnt <= (COLS == 1) ? CW'(0) : CW'(1);
                end else begin
                    r_cnt <= w_last ? CW'(0) : r_cnt + CW'(1);
                end
            end
            for (int i = 1; i <= COLS; i++) begin
                if (w_wr_sel[i]) begin
                    r_f[i] <= i_in_data;
                end
            end
        end
    end

    assign o_f = r_f;

`ifdef VECDESER_MIN_EN
    logic signed [WIDTH-1:0] r_fmin;

    // Running minimum, restarted by each write to the first element; ties keep the earlier value
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fmin <= '0;
        end else if (w_wr_sel[1]) begin
            r_fmin <= i_in_data;
        end else if (w_accept && (i_in_data < r_fmin)) begin
            r_fmin <= i_in_data;
        end
    end

    assign o_fmin = r_fmin;
`endif

endmodule

// File: tb/tb_vecdeser.sv
// Testbench for vecdeser (COLS=4, WIDTH=16): directed vectors with a
// queue-based reference model checked every cycle, plus literal expectations.
module tb_vecdeser;

    localparam int COLS = 4;
    localparam int W    = 16;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [W-1:0]      in_data;
    logic [COLS:1][W-1:0]     f;
    logic                     f_valid;
    logic                     f_ready;
`ifdef VECDESER_MIN_EN
    logic signed [W-1:0]      fmin;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vecdeser #(.COLS(COLS), .WIDTH(W)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_f        (f),
`ifdef VECDESER_MIN_EN
        .o_fmin     (fmin),
`endif
        .o_f_valid  (f_valid),
        .i_f_ready  (f_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_vec[COLS];
    bit           m_full = 1'b0;

    function automatic logic [63:0] m_packed();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < COLS; i++) v[i*W +: W] = m_vec[i];
        return v;
    endfunction

    function automatic logic [W-1:0] m_min();
        int mn;
        mn = $signed(m_vec[0]);
        for (int i = 1; i < COLS; i++)
            if ($signed(m_vec[i]) < mn) mn = $signed(m_vec[i]);
        return W'(mn);
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit outv;
        acc  = in_valid && !reset && (!m_full || f_ready);
        outv = m_full && f_ready;
        if (reset) begin
            m_part.delete();
            m_full = 1'b0;
        end else begin
            if (outv) m_full = 1'b0;
            if (acc) begin
                m_part.push_back(in_data);
                if (m_part.size() == COLS) begin
                    for (int i = 0; i < COLS; i++) m_vec[i] = m_part[i];
                    m_part.delete();
                    m_full = 1'b1;
                end
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(!reset && (!m_full || f_ready)));
        check("f_valid", 64'(f_valid), 64'(m_full));
        if (m_full) begin
            check("f_vec", 64'(f), m_packed());
`ifdef VECDESER_MIN_EN
            check("fmin", 64'(fmin), 64'(m_min()));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] d);
        bit rdy;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic consume();
        f_ready  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        f_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        f_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_f_valid", 64'(f_valid), 64'd0);
        check("rst_f", 64'(f), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // basic fill
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        in_valid = 1'b0;
        check("fill_valid", 64'(f_valid), 64'd1);
        check("fill_vec", 64'(f), {16'd4, 16'd3, 16'd2, 16'd1});
        check("fill_ready_low", 64'(in_ready), 64'd0);

        // backpressure hold with pending element 9
        in_valid = 1'b1;
        in_data  = 16'd9;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("bp_hold_vec", 64'(f), {16'd4, 16'd3, 16'd2, 16'd1});
        check("bp_hold_valid", 64'(f_valid), 64'd1);
        f_ready = 1'b1;
        @(posedge clk);
        #1;
        f_ready  = 1'b0;
        in_valid = 1'b0;
        check("bp_drain_valid", 64'(f_valid), 64'd0);
        check("bp_f1", 64'(f[1]), 64'd9);
        send(16'd10); send(16'd11); send(16'd12);
        in_valid = 1'b0;
        check("bp_vec", 64'(f), {16'd12, 16'd11, 16'd10, 16'd9});
        consume();

        // streaming 0..11 with consumer always ready
        f_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            @(negedge clk);
            check("stream_no_stall", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i == 3) check("stream_v0", 64'(f), {16'd3, 16'd2, 16'd1, 16'd0});
            if (i == 7) check("stream_v1", 64'(f), {16'd7, 16'd6, 16'd5, 16'd4});
        end
        in_valid = 1'b0;
        check("stream_v2", 64'(f), {16'd11, 16'd10, 16'd9, 16'd8});
        check("stream_v2_valid", 64'(f_valid), 64'd1);
        @(posedge clk);
        #1;
        f_ready = 1'b0;
        check("stream_drained", 64'(f_valid), 64'd0);

        // gapped input
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = W'(20 + i);
            @(posedge clk);
            #1;
            idle(1);
        end
        check("gap_vec", 64'(f), {16'd23, 16'd22, 16'd21, 16'd20});
        check("gap_valid", 64'(f_valid), 64'd1);
        consume();

        // reset mid-fill
        send(16'd5); send(16'd6);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_f_valid", 64'(f_valid), 64'd0);
        reset = 1'b0;
        #1;
        check("after_rst_f_valid", 64'(f_valid), 64'd0);
        send(16'd7); send(16'd8); send(16'd9);
        in_valid = 1'b0;
        check("after_rst_not_full", 64'(f_valid), 64'd0);
        send(16'd10);
        in_valid = 1'b0;
        check("after_rst_vec", 64'(f), {16'd10, 16'd9, 16'd8, 16'd7});
        consume();

        // signed minimum vectors
        send(16'd3); send(16'hFFFE); send(16'hFFFE); send(16'h7FFF);
        in_valid = 1'b0;
        check("min_vec", 64'(f), {16'h7FFF, 16'hFFFE, 16'hFFFE, 16'd3});
`ifdef VECDESER_MIN_EN
        check("fmin_neg", 64'(fmin), 64'(16'hFFFE));
`endif
        consume();
        send(16'd5); send(16'd5); send(16'd5); send(16'd5);
        in_valid = 1'b0;
        check("min_vec2", 64'(f), {16'd5, 16'd5, 16'd5, 16'd5});
`ifdef VECDESER_MIN_EN
        check("fmin_fresh", 64'(fmin), 64'd5);
`endif
        consume();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
